// File: rtl/event_pulse_if.sv
// Event-to-pulse bus: trigger/control strobes in, physical pulse and status out.
interface event_pulse_if #(
    parameter int PEND_W = 3
);
    logic              trigger;
    logic              cancel;
    logic              clear_overflow;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic              pulse_done;

    modport master (
        output trigger, cancel, clear_overflow,
        input  led, busy, pending, overflow, pulse_done
    );

    modport slave (
        input  trigger, cancel, clear_overflow,
        output led, busy, pending, overflow, pulse_done
    );
endinterface

// File: rtl/event_pulse_driver.sv
// Stretches single-cycle events into fixed-length LED/buzzer pulses with a
// guaranteed low gap, queueing early events in a saturating counter.
module event_pulse_driver #(
    parameter int CNT_W      = 16,
    parameter int ON_CYCLES  = 50000,
    parameter int OFF_CYCLES = 50000,
    parameter int PEND_W     = 3
) (
    input  logic         clk,
    input  logic         reset,
    event_pulse_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ON, GAP} stateType;

    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    stateType          state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [PEND_W-1:0] pendReg, pendNext;
    logic              ledReg, busyReg, ovfReg, doneReg;
    logic              doneNext, setOvf;
    logic              onLast, gapLast;

    assign onLast  = (cnt == ON_LAST);
    assign gapLast = (cnt == OFF_LAST);

    // Next-state logic; cancel overrides everything except the sticky overflow.
    always_comb begin
        stateNext = state;
        cntNext   = cnt + CNT_W'(1);
        pendNext  = pendReg;
        doneNext  = 1'b0;
        setOvf    = 1'b0;
        if (bus.cancel) begin
            stateNext = IDLE;
            cntNext   = '0;
            pendNext  = '0;
        end else begin
            case (state)
                IDLE: begin
                    cntNext = '0;
                    if (bus.trigger) stateNext = ON;
                end
                ON: begin
                    if (onLast) begin
                        stateNext = GAP;
                        cntNext   = '0;
                        doneNext  = 1'b1;
                    end
                    if (bus.trigger) begin
                        if (pendReg == PEND_MAX) setOvf = 1'b1;
                        else                     pendNext = pendReg + PEND_W'(1);
                    end
                end
                GAP: begin
                    if (gapLast) begin
                        cntNext = '0;
                        // A trigger here swaps in for the dequeued entry, so pending only drops without one.
                        if (pendReg != '0 || bus.trigger) stateNext = ON;
                        else                              stateNext = IDLE;
                        if (pendReg != '0 && !bus.trigger) pendNext = pendReg - PEND_W'(1);
                    end else if (bus.trigger) begin
                        if (pendReg == PEND_MAX) setOvf = 1'b1;
                        else                     pendNext = pendReg + PEND_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pendReg <= '0;
            ledReg  <= 1'b0;
            busyReg <= 1'b0;
            ovfReg  <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            pendReg <= pendNext;
            ledReg  <= (stateNext == ON);
            busyReg <= (stateNext != IDLE);
            doneReg <= doneNext;
            if (setOvf)                  ovfReg <= 1'b1;
            else if (bus.clear_overflow) ovfReg <= 1'b0;
        end
    end

    assign bus.led        = ledReg;
    assign bus.busy       = busyReg;
    assign bus.pending    = pendReg;
    assign bus.overflow   = ovfReg;
    assign bus.pulse_done = doneReg;
endmodule

// File: tb/tb_event_pulse_driver.sv
// Directed bench for event_pulse_driver with ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
module tb_event_pulse_driver;
    localparam int CNT_W = 16;
    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    event_pulse_if #(.PEND_W(PW)) bus();

    event_pulse_driver #(
        .CNT_W(CNT_W), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_W(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string name);
        int budget = 60;
        while (bus.busy && budget > 0) begin
            tick();
            budget--;
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s idle timeout busy=%b want 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.trigger = 0; bus.cancel = 0; bus.clear_overflow = 0;
        reset = 1'b1;
        tick(); tick();
        vectors += 5;
        if (bus.led !== 1'b0)        begin miscompares++; $display("[TB] FAIL reset_led got %b want 0", bus.led); end
        if (bus.busy !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.pending !== 2'd0)    begin miscompares++; $display("[TB] FAIL reset_pending got %0d want 0", bus.pending); end
        if (bus.overflow !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); end
        if (bus.pulse_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", bus.pulse_done); end
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single();
        logic expLed, expDone, expBusy;
        for (int c = 0; c < 9; c++) begin
            bus.trigger = (c == 0);
            tick();
            expLed  = (c + 1 >= 1 && c + 1 <= 4);
            expDone = (c + 1 == 5);
            expBusy = (c + 1 <= 7);
            vectors += 4;
            if (bus.led !== expLed)         begin miscompares++; $display("[TB] FAIL single_led k=%0d got %b want %b", c + 1, bus.led, expLed); end
            if (bus.pulse_done !== expDone) begin miscompares++; $display("[TB] FAIL single_done k=%0d got %b want %b", c + 1, bus.pulse_done, expDone); end
            if (bus.busy !== expBusy)       begin miscompares++; $display("[TB] FAIL single_busy k=%0d got %b want %b", c + 1, bus.busy, expBusy); end
            if (bus.pending !== 2'd0)       begin miscompares++; $display("[TB] FAIL single_pending k=%0d got %0d want 0", c + 1, bus.pending); end
        end
        bus.trigger = 0;
    endtask

    task automatic test_queue();
        int k;
        logic expLed, expBusy;
        logic [1:0] expPend;
        for (int c = 0; c < 23; c++) begin
            bus.trigger = (c == 0 || c == 2 || c == 3);
            tick();
            k = c + 1;
            expLed  = (k >= 1 && k <= 4) || (k >= 8 && k <= 11) || (k >= 15 && k <= 18);
            expBusy = (k <= 21);
            if (k == 3)                expPend = 2'd1;
            else if (k >= 4 && k <= 7) expPend = 2'd2;
            else if (k >= 8 && k <= 14) expPend = 2'd1;
            else                        expPend = 2'd0;
            vectors += 3;
            if (bus.led !== expLed)      begin miscompares++; $display("[TB] FAIL queue_led k=%0d got %b want %b", k, bus.led, expLed); end
            if (bus.busy !== expBusy)    begin miscompares++; $display("[TB] FAIL queue_busy k=%0d got %b want %b", k, bus.busy, expBusy); end
            if (bus.pending !== expPend) begin miscompares++; $display("[TB] FAIL queue_pending k=%0d got %0d want %0d", k, bus.pending, expPend); end
        end
        bus.trigger = 0;
    endtask

    task automatic test_saturation();
        int k;
        int edges = 0;
        logic prevLed = 1'b0;
        for (int c = 0; c < 9; c++) begin
            bus.trigger        = (c <= 4 || c == 6);
            bus.clear_overflow = (c == 5 || c == 6 || c == 7);
            tick();
            k = c + 1;
            if (bus.led && !prevLed) edges++;
            prevLed = bus.led;
            if (k == 4) begin
                vectors++;
                if (bus.pending !== 2'd3) begin miscompares++; $display("[TB] FAIL sat_pending k=4 got %0d want 3", bus.pending); end
            end
            if (k == 5) begin
                vectors++;
                if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_ovf_set got %b want 1", bus.overflow); end
            end
            if (k == 6) begin
                vectors++;
                if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_ovf_clear got %b want 0", bus.overflow); end
            end
            if (k == 7) begin
                vectors += 2;
                if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_set_wins got %b want 1", bus.overflow); end
                if (bus.pending !== 2'd3)  begin miscompares++; $display("[TB] FAIL sat_pending k=7 got %0d want 3", bus.pending); end
            end
            if (k == 8) begin
                vectors += 2;
                if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_ovf_clear2 got %b want 0", bus.overflow); end
                if (bus.pending !== 2'd2)  begin miscompares++; $display("[TB] FAIL sat_pending k=8 got %0d want 2", bus.pending); end
            end
        end
        bus.trigger = 0;
        bus.clear_overflow = 0;
        for (int i = 0; i < 60 && bus.busy; i++) begin
            tick();
            if (bus.led && !prevLed) edges++;
            prevLed = bus.led;
        end
        vectors += 2;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_idle busy=%b want 0", bus.busy); end
        if (edges != 4)        begin miscompares++; $display("[TB] FAIL sat_pulses got %0d want 4", edges); end
    endtask

    task automatic test_last_gap_trigger();
        int k;
        for (int c = 0; c < 23; c++) begin
            bus.trigger = (c == 0 || c == 7 || c == 9 || c == 14);
            tick();
            k = c + 1;
            case (k)
                7: begin
                    vectors++;
                    if (bus.led !== 1'b0) begin miscompares++; $display("[TB] FAIL lg_gap_led got %b want 0", bus.led); end
                end
                8, 15: begin
                    vectors += 2;
                    if (bus.led !== 1'b1) begin miscompares++; $display("[TB] FAIL lg_rise k=%0d got %b want 1", k, bus.led); end
                    if (bus.pending !== ((k == 8) ? 2'd0 : 2'd1)) begin
                        miscompares++; $display("[TB] FAIL lg_pending k=%0d got %0d want %0d", k, bus.pending, (k == 8) ? 0 : 1);
                    end
                end
                14: begin
                    vectors += 2;
                    if (bus.led !== 1'b0)     begin miscompares++; $display("[TB] FAIL lg_gap2_led got %b want 0", bus.led); end
                    if (bus.pending !== 2'd1) begin miscompares++; $display("[TB] FAIL lg_pending k=14 got %0d want 1", bus.pending); end
                end
                22: begin
                    vectors += 2;
                    if (bus.led !== 1'b1)     begin miscompares++; $display("[TB] FAIL lg_third_led got %b want 1", bus.led); end
                    if (bus.pending !== 2'd0) begin miscompares++; $display("[TB] FAIL lg_pending k=22 got %0d want 0", bus.pending); end
                end
                default: ;
            endcase
        end
        bus.trigger = 0;
        waitIdle("lg_drain");
    endtask

    task automatic test_cancel();
        int k;
        for (int c = 0; c < 22; c++) begin
            bus.trigger = (c <= 3 || c == 9);
            bus.cancel  = (c == 9);
            tick();
            k = c + 1;
            if (k == 9) begin
                vectors += 2;
                if (bus.led !== 1'b1)     begin miscompares++; $display("[TB] FAIL cancel_pre_led got %b want 1", bus.led); end
                if (bus.pending !== 2'd2) begin miscompares++; $display("[TB] FAIL cancel_pre_pending got %0d want 2", bus.pending); end
            end
            if (k == 10) begin
                vectors += 2;
                if (bus.pending !== 2'd0)    begin miscompares++; $display("[TB] FAIL cancel_pending got %0d want 0", bus.pending); end
                if (bus.pulse_done !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_done got %b want 0", bus.pulse_done); end
            end
            if (k >= 10) begin
                vectors += 2;
                if (bus.led !== 1'b0)  begin miscompares++; $display("[TB] FAIL cancel_led k=%0d got %b want 0", k, bus.led); end
                if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_busy k=%0d got %b want 0", k, bus.busy); end
            end
        end
        bus.trigger = 0;
        bus.cancel  = 0;
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 5; c++) begin
            bus.trigger = 1'b1;
            tick();
        end
        bus.trigger = 0;
        vectors += 2;
        if (bus.pulse_done !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_pre_done got %b want 1", bus.pulse_done); end
        if (bus.overflow !== 1'b1)   begin miscompares++; $display("[TB] FAIL ar_pre_ovf got %b want 1", bus.overflow); end
        #3 reset = 1'b1;
        #1;
        vectors += 5;
        if (bus.led !== 1'b0)        begin miscompares++; $display("[TB] FAIL ar_led got %b want 0", bus.led); end
        if (bus.busy !== 1'b0)       begin miscompares++; $display("[TB] FAIL ar_busy got %b want 0", bus.busy); end
        if (bus.pending !== 2'd0)    begin miscompares++; $display("[TB] FAIL ar_pending got %0d want 0", bus.pending); end
        if (bus.overflow !== 1'b0)   begin miscompares++; $display("[TB] FAIL ar_ovf got %b want 0", bus.overflow); end
        if (bus.pulse_done !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_done got %b want 0", bus.pulse_done); end
        @(posedge clk);
        #2 reset = 1'b0;
        tick(); tick();
        vectors++;
        if (bus.led !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_no_pulse got %b want 0", bus.led); end
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        vectors += 2;
        if (bus.led !== 1'b1)     begin miscompares++; $display("[TB] FAIL ar_latency got %b want 1", bus.led); end
        if (bus.pending !== 2'd0) begin miscompares++; $display("[TB] FAIL ar_pending_post got %0d want 0", bus.pending); end
        for (int i = 2; i <= 5; i++) begin
            tick();
            vectors++;
            if (bus.led !== (i <= 4)) begin miscompares++; $display("[TB] FAIL ar_width k=%0d got %b want %b", i, bus.led, (i <= 4)); end
        end
        waitIdle("ar_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_queue();
        tick();
        test_saturation();
        tick();
        test_last_gap_trigger();
        tick();
        test_cancel();
        tick();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
